// File: rtl/data_memory.sv
// data_memory: word-organised RAM with combinational read, clocked write and synchronous clear.
// Define DATA_MEMORY_BOUNDS_CHECK_EN to add out_addr_error and block out-of-range accesses.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           in_address,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  input  logic                  in_write_enable,
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  output logic                  out_addr_error,
`endif
  output logic [DATA_WIDTH-1:0] out_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic addr_ok;
  assign idx = in_address[ADDR_BITS-1:0];
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  assign addr_ok = in_address < 32'(DEPTH);
  assign out_addr_error = !addr_ok;
`else
  // Upper address bits alias onto the array, so they play no part in decoding.
  logic unused_hi;
  assign unused_hi = ^in_address[31:ADDR_BITS];
  assign addr_ok = 1'b1;
`endif
  assign out_data = addr_ok ? mem[idx] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (in_write_enable && addr_ok) begin
      mem[idx] <= in_write_data;
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scoreboard bench for data_memory (either build of the bounds-check option).
module tb_data_memory;
  logic clk = 1'b0;
  logic reset, in_write_enable;
  logic [31:0] in_address, in_write_data, out_data;
  logic [31:0] sb [$];
  logic [31:0] ref_mem [64];
  int total = 0;
  int bad = 0;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic out_addr_error;
`endif

  data_memory dut (
    .clk(clk),
    .reset(reset),
    .in_address(in_address),
    .in_write_data(in_write_data),
    .in_write_enable(in_write_enable),
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    .out_addr_error(out_addr_error),
`endif
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] v);
    in_address = a;
    #1;
    push(v);
    cmp(tag, out_data);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    in_address = a;
    in_write_data = d;
    in_write_enable = 1'b1;
    tick();
    in_write_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_write_enable = 1'b0;
    in_address = '0;
    in_write_data = '0;
    tick();
    reset = 1'b0;
    rd("rst_a0", 0, 0);
    rd("rst_a5", 5, 0);
    rd("rst_a63", 63, 0);
    wr(0, 10);
    wr(1, 20);
    rd("wr_a0", 0, 10);
    rd("wr_a1", 1, 20);
    in_address = 0;
    in_write_data = 99;
    tick();
    rd("gate_a0", 0, 10);
    in_address = 1;
    in_write_data = 30;
    in_write_enable = 1'b1;
    #1;
    push(20);
    cmp("rdw_before", out_data);
    tick();
    push(30);
    cmp("rdw_after", out_data);
    in_write_enable = 1'b0;
    wr(63, 32'hdeadbeef);
    rd("top_a63", 63, 32'hdeadbeef);
    rd("top_a0", 0, 10);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    wr(64, 7);
    in_address = 64;
    #1;
    push(1);
    cmp("oob_err", {31'b0, out_addr_error});
    push(0);
    cmp("oob_data", out_data);
    in_address = 63;
    #1;
    push(0);
    cmp("inb_err", {31'b0, out_addr_error});
    rd("oob_a0", 0, 10);
`else
    wr(64, 7);
    rd("wrap_a0", 0, 7);
    rd("wrap_a64", 64, 7);
    rd("wrap_a65", 65, 30);
    rd("wrap_hi", 32'h8000_0001, 30);
`endif
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'hx;
    for (int i = 0; i < 8; i++) begin
      ref_mem[i * 8 + 2] = $urandom;
      wr(i * 8 + 2, ref_mem[i * 8 + 2]);
    end
    for (int i = 0; i < 8; i++) rd($sformatf("rand_a%0d", i * 8 + 2), i * 8 + 2, ref_mem[i * 8 + 2]);
    in_address = 1;
    in_write_data = 55;
    in_write_enable = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_write_enable = 1'b0;
    rd("mid_rst_a1", 1, 0);
    rd("mid_rst_a0", 0, 0);
    rd("mid_rst_a63", 63, 0);
    rd("mid_rst_a10", 10, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
